// File: rtl/macro_sched.sv
// macro_sched: hands one shared pad set to one macro at a time, manual or round-robin, with a break-before-make guard.
// Define MACRO_SCHED_LA_OVERRIDE_EN to let the logic analyzer force a manual selection.
module macro_sched #(
    parameter int          N_MACRO   = 4,
    parameter int          DWELL_W   = 16,
    parameter int          GUARD_CYC = 4,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [38*N_MACRO-1:0]   m_io_out_i,
    input  logic [38*N_MACRO-1:0]   m_io_oeb_i,
    output logic [37:0]             io_out,
    output logic [37:0]             io_oeb,
    output logic [N_MACRO-1:0]      active_o,
    input  logic                    la_ovr_i,
    input  logic [2:0]              la_ovr_sel_i
);
    localparam int         GW   = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [2:0] LAST = 3'(N_MACRO - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GUARD = 2'd1, S_RUN = 2'd2} state_t;

    state_t               r_state, w_state_n;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_en, r_auto;
    logic [2:0]           r_sel;
    logic [DWELL_W-1:0]   r_dwell;
    logic [2:0]           r_cur, w_cur_n, r_tgt, w_tgt_n;
    logic [GW-1:0]        r_gcnt, w_gcnt_n;
    logic [DWELL_W-1:0]   r_dcnt, w_dcnt_n;
    logic [7:0]           r_rounds, w_rounds_n;
    logic                 w_hit, w_req, w_ovr, w_en, w_auto, w_unused;
    logic [2:0]           w_sel_raw, w_sel;
    logic [31:0]          w_rd, w_mask;
    logic [DWELL_W-1:0]   w_dwell_ld;

    assign w_hit    = wbs_adr_i[31:8] == BASE_ADR[31:8];
    assign w_req    = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
    assign w_mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i, w_mask, la_ovr_i, la_ovr_sel_i};

`ifdef MACRO_SCHED_LA_OVERRIDE_EN
    assign w_ovr     = la_ovr_i;
    assign w_en      = r_en | la_ovr_i;
    assign w_auto    = r_auto & ~la_ovr_i;
    assign w_sel_raw = la_ovr_i ? la_ovr_sel_i : r_sel;
`else
    assign w_ovr     = 1'b0;
    assign w_en      = r_en;
    assign w_auto    = r_auto;
    assign w_sel_raw = r_sel;
`endif

    assign w_sel      = (32'(w_sel_raw) >= N_MACRO) ? LAST : w_sel_raw;
    assign w_dwell_ld = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;

    always_comb begin
        w_rd = '0;
        case (wbs_adr_i[7:2])
            6'h00:   w_rd = {25'b0, r_sel, 2'b0, r_auto, r_en};
            6'h01:   w_rd = 32'(r_dwell);
            6'h02:   w_rd = {16'b0, r_rounds, w_ovr, 1'b0, r_state, 1'b0, r_cur};
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_sel   <= '0;
            r_dwell <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rd : '0;
            if (w_req && wbs_we_i && wbs_adr_i[7:2] == 6'h00 && wbs_sel_i[0]) begin
                r_en   <= wbs_dat_i[0];
                r_auto <= wbs_dat_i[1];
                r_sel  <= wbs_dat_i[6:4];
            end
            if (w_req && wbs_we_i && wbs_adr_i[7:2] == 6'h01)
                r_dwell <= (r_dwell & ~w_mask[DWELL_W-1:0]) | (wbs_dat_i[DWELL_W-1:0] & w_mask[DWELL_W-1:0]);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_tgt    <= '0;
            r_gcnt   <= '0;
            r_dcnt   <= '0;
            r_rounds <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cur    <= w_cur_n;
            r_tgt    <= w_tgt_n;
            r_gcnt   <= w_gcnt_n;
            r_dcnt   <= w_dcnt_n;
            r_rounds <= w_rounds_n;
        end
    end

    // EN=0 beats everything; in AUTO, dwell expiry beats any SEL change
    always_comb begin
        w_state_n  = r_state;
        w_cur_n    = r_cur;
        w_tgt_n    = r_tgt;
        w_gcnt_n   = r_gcnt;
        w_dcnt_n   = r_dcnt;
        w_rounds_n = r_rounds;
        case (r_state)
            S_IDLE: if (w_en) begin
                w_state_n = S_GUARD;
                w_tgt_n   = w_auto ? 3'd0 : w_sel;
                w_gcnt_n  = GW'(GUARD_CYC - 1);
            end
            S_GUARD: begin
                if (!w_en) w_state_n = S_IDLE;
                else if (r_gcnt == '0) begin
                    w_state_n = S_RUN;
                    w_cur_n   = r_tgt;
                    w_dcnt_n  = w_dwell_ld;
                end else w_gcnt_n = r_gcnt - GW'(1);
            end
            S_RUN: begin
                w_dcnt_n = (r_dcnt > DWELL_W'(1)) ? r_dcnt - DWELL_W'(1) : r_dcnt;
                if (!w_en) w_state_n = S_IDLE;
                else if (w_auto ? (r_dcnt <= DWELL_W'(1)) : (w_sel != r_cur)) begin
                    w_state_n  = S_GUARD;
                    w_gcnt_n   = GW'(GUARD_CYC - 1);
                    w_tgt_n    = !w_auto ? w_sel : (r_cur == LAST) ? 3'd0 : r_cur + 3'd1;
                    w_rounds_n = (w_auto && r_cur == LAST) ? r_rounds + 8'd1 : r_rounds;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign active_o  = (r_state == S_RUN) ? N_MACRO'(1) << r_cur : '0;
    assign io_out    = (r_state == S_RUN) ? m_io_out_i[38*int'(r_cur) +: 38] : '0;
    assign io_oeb    = (r_state == S_RUN) ? m_io_oeb_i[38*int'(r_cur) +: 38] : '1;
endmodule

// File: tb/tb_macro_sched.sv
// tb_macro_sched: directed checks of bus access, manual select, round-robin, disable and reset for macro_sched.
module tb_macro_sched;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic               stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]         sel = 4'h0;
    logic [31:0]        adr = '0, wdat = '0;
    logic               ack;
    logic [31:0]        rdat;
    logic [38*N-1:0]    m_out = '0, m_oeb = '0;
    logic [37:0]        io_out, io_oeb;
    logic [N-1:0]       active;
    logic               la_ovr = 1'b0;
    logic [2:0]         la_sel = 3'd0;
    logic [37:0]        exp_out [N];
    logic [37:0]        exp_oeb [N];
    int                 total = 0, bad = 0;

    always #5 clk = ~clk;

    macro_sched #(.N_MACRO(N), .DWELL_W(16), .GUARD_CYC(4), .BASE_ADR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .m_io_out_i(m_out), .m_io_oeb_i(m_oeb), .io_out(io_out), .io_oeb(io_oeb),
        .active_o(active), .la_ovr_i(la_ovr), .la_ovr_sel_i(la_sel)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic exp_ack,
                      output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = '0;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                q = rdat;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("ack", got, exp_ack);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] q;
        wb(1'b1, BASE + 32'(off), d, 1'b1, q);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] q;
        wb(1'b0, BASE + 32'(off), 32'h0, 1'b1, q);
        chk(tag, q, exp);
    endtask

    initial begin
        logic [31:0] q;
        logic [3:0]  e;
        int          p, k;
        for (int i = 0; i < N; i++) begin
            exp_out[i] = {6'(i + 1), 32'hC0DE_0000 + 32'(i)};
            exp_oeb[i] = {6'(2 * i + 1), 32'hF00D_0000 ^ 32'(i)};
            m_out[38*i +: 38] = exp_out[i];
            m_oeb[38*i +: 38] = exp_oeb[i];
        end
        tick(2);
        chk("rst_active", active, 0);
        chk("rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        chk("rst_out", io_out, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        rst_n = 1'b1;
        rd(8'h00, 32'h0, "rst_ctrl");
        rd(8'h04, 32'h0, "rst_dwell");
        rd(8'h08, 32'h0, "rst_status");

        wr(8'h00, 32'h21);
        chk("m_guard0", active, 0);
        tick(4);
        chk("m_guard4", active, 0);
        chk("m_guard_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        tick(1);
        chk("m_run2", active, 4'b0100);
        chk("m_out2", io_out, exp_out[2]);
        chk("m_oeb2", io_oeb, exp_oeb[2]);
        rd(8'h08, 32'h22, "m_status");

        wr(8'h00, 32'h71);
        chk("clamp_old", active, 4'b0100);
        tick(1);
        chk("clamp_g1", active, 0);
        tick(3);
        chk("clamp_g4", active, 0);
        tick(1);
        chk("clamp_run3", active, 4'b1000);
        chk("clamp_out3", io_out, exp_out[3]);
        rd(8'h08, 32'h23, "clamp_status");

        wr(8'h00, 32'h31);
        tick(3);
        chk("same_sel", active, 4'b1000);

        wr(8'h00, 32'h30);
        chk("dis_run_old", active, 4'b1000);
        tick(1);
        chk("dis_run", active, 0);
        chk("dis_run_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        rd(8'h08, 32'h03, "dis_run_status");

        wr(8'h00, 32'h01);
        tick(2);
        chk("dis_g_pre", active, 0);
        wr(8'h00, 32'h00);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("dis_g%0d", i), active, 0);
        end
        rd(8'h08, 32'h03, "dis_g_status");

        wr(8'h04, 32'h3);
        rd(8'h04, 32'h3, "dwell_rd");
        wr(8'h00, 32'h03);
        for (int t = 1; t <= 29; t++) begin
            tick(1);
            p = (t - 1) % 7;
            k = (t - 1) / 7;
            e = (p >= 4) ? 4'(1 << (k % 4)) : 4'd0;
            chk($sformatf("rr%0d", t), active, e);
            if (t == 13) chk("rr_out1", io_out, exp_out[1]);
        end
        rd(8'h08, 32'h113, "rr_rounds");

        wb(1'b1, BASE + 32'h100, 32'hFF, 1'b0, q);
        rd(8'h0C, 32'h0, "rd_0c");
        rd(8'h40, 32'h0, "rd_40");

        for (int i = 0; i < 20 && active == 0; i++) tick(1);
        chk("rr_resume", active != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_active", active, 0);
        chk("arst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        chk("arst_out", io_out, 0);
        tick(1);
        rst_n = 1'b1;
        rd(8'h00, 32'h0, "arst_ctrl");
        rd(8'h04, 32'h0, "arst_dwell");
        rd(8'h08, 32'h0, "arst_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
